// File: rtl/ft_device.sv
// rtl/ft_device.sv - FT60x synchronous 245-FIFO chip-side responder
//
// Stands in for the FTDI chip: serves master reads from an RX buffer filled
// by the host stream, and captures master writes into a TX buffer drained by
// the host stream.
//
// Ports:
//   clk, rst                 FT clock (rising edge), async active-high reset
//   ft_rxf, ft_txe           active-low data-available / space-available flags
//   ft_data, ft_be           shared bus, driven by this block while ft_oe=0
//   ft_rd, ft_wr, ft_oe      active-low master strobes
//   host_din*                host push side of the RX buffer
//   host_dout*               host pop side of the TX buffer (fall-through)
//   rx_hold, tx_hold         force ft_rxf / ft_txe high from the next edge
//   rx_level, tx_level       buffer occupancies
//   err_conflict             sticky protocol-error flag
module ft_device #(
    parameter int BUS_WIDTH = 16,
    parameter int DEPTH     = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             ft_rxf,
    output logic                             ft_txe,
    inout  wire  [BUS_WIDTH-1:0]             ft_data,
    inout  wire  [BUS_WIDTH/8-1:0]           ft_be,
    input  logic                             ft_rd,
    input  logic                             ft_wr,
    input  logic                             ft_oe,
    input  logic [BUS_WIDTH-1:0]             host_din,
    input  logic [BUS_WIDTH/8-1:0]           host_din_be,
    input  logic                             host_din_valid,
    output logic                             host_din_full,
    output logic [BUS_WIDTH-1:0]             host_dout,
    output logic [BUS_WIDTH/8-1:0]           host_dout_be,
    output logic                             host_dout_empty,
    input  logic                             host_dout_get,
    input  logic                             rx_hold,
    input  logic                             tx_hold,
    output logic [$clog2(DEPTH):0]           rx_level,
    output logic [$clog2(DEPTH):0]           tx_level,
    output logic                             err_conflict
);

    localparam int BE_W = BUS_WIDTH / 8;
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int EW   = BUS_WIDTH + BE_W;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ZERO = '0;

    // ------------------------------------------------------------------
    // RX buffer: host -> master. Entries stored as {be, data}.
    // ------------------------------------------------------------------
    logic [EW-1:0]   rx_mem [DEPTH];
    logic [AW-1:0]   rx_wr_ptr;
    logic [AW-1:0]   rx_rd_ptr;
    logic [EW-1:0]   rx_head;
    logic            rx_push;
    logic            rx_pop;
    logic [LW-1:0]   rx_level_next;
    logic            bus_en;

    assign host_din_full = (rx_level == LVL_FULL);
    assign rx_push       = host_din_valid & ~host_din_full;
    // ft_rxf=0 guarantees a non-empty buffer, since it was registered from
    // the level seen at the previous edge.
    assign rx_pop        = ~ft_oe & ~ft_rd & ~ft_rxf;
    assign rx_level_next = rx_level + {{(LW-1){1'b0}}, rx_push}
                                    - {{(LW-1){1'b0}}, rx_pop};
    assign rx_head       = rx_mem[rx_rd_ptr];

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= {host_din_be, host_din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
            ft_rxf    <= 1'b1;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + AW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + AW'(1);
            end
            rx_level <= rx_level_next;
            ft_rxf   <= (rx_level_next == LVL_ZERO) | rx_hold;
        end
    end

    // Reset gates the drive directly so the bus is released without an edge.
    // An empty buffer still drives its stale head; the master ignores it.
    assign bus_en  = ~ft_oe & ~rst;
    assign ft_data = bus_en ? rx_head[BUS_WIDTH-1:0] : {BUS_WIDTH{1'bz}};
    assign ft_be   = bus_en ? rx_head[EW-1:BUS_WIDTH] : {BE_W{1'bz}};

    // ------------------------------------------------------------------
    // TX buffer: master -> host.
    // ------------------------------------------------------------------
    logic [EW-1:0]   tx_mem [DEPTH];
    logic [AW-1:0]   tx_wr_ptr;
    logic [AW-1:0]   tx_rd_ptr;
    logic [EW-1:0]   tx_head;
    logic            tx_push;
    logic            tx_pop;
    logic [LW-1:0]   tx_level_next;

    // ft_txe is registered high once the level reaches DEPTH, so a write
    // accepted here can never overflow.
    assign tx_push       = ~ft_wr & ~ft_txe & ft_oe;
    assign host_dout_empty = (tx_level == LVL_ZERO);
    assign tx_pop        = host_dout_get & ~host_dout_empty;
    assign tx_level_next = tx_level + {{(LW-1){1'b0}}, tx_push}
                                    - {{(LW-1){1'b0}}, tx_pop};
    assign tx_head       = tx_mem[tx_rd_ptr];
    assign host_dout     = tx_head[BUS_WIDTH-1:0];
    assign host_dout_be  = tx_head[EW-1:BUS_WIDTH];

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= {ft_be, ft_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
            ft_txe    <= 1'b1;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + AW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + AW'(1);
            end
            tx_level <= tx_level_next;
            ft_txe   <= (tx_level_next == LVL_FULL) | tx_hold;
        end
    end

    // ------------------------------------------------------------------
    // Protocol error: master writing while we drive, or reading without
    // letting us drive.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_conflict <= 1'b0;
        end else if ((~ft_oe & ~ft_wr) | (~ft_rd & ft_oe)) begin
            err_conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ft_device.sv
// tb/tb_ft_device.sv - randomized queue-model bench for ft_device
module tb_ft_device;

    localparam int BW = 16;
    localparam int BE = BW / 8;
    localparam int D  = 64;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ft_rxf, ft_txe;
    wire  [BW-1:0] ft_data;
    wire  [BE-1:0] ft_be;
    logic          ft_rd = 1'b1, ft_wr = 1'b1, ft_oe = 1'b1;
    logic [BW-1:0] host_din = '0;
    logic [BE-1:0] host_din_be = '0;
    logic          host_din_valid = 1'b0;
    logic          host_din_full;
    logic [BW-1:0] host_dout;
    logic [BE-1:0] host_dout_be;
    logic          host_dout_empty;
    logic          host_dout_get = 1'b0;
    logic          rx_hold = 1'b0, tx_hold = 1'b0;
    logic [LW-1:0] rx_level, tx_level;
    logic          err_conflict;

    logic          tb_drv = 1'b0;
    logic [BW-1:0] tb_data = '0;
    logic [BE-1:0] tb_be = '0;

    assign ft_data = tb_drv ? tb_data : {BW{1'bz}};
    assign ft_be   = tb_drv ? tb_be   : {BE{1'bz}};

    always #5 clk = ~clk;

    ft_device #(.BUS_WIDTH(BW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ft_rxf(ft_rxf), .ft_txe(ft_txe),
        .ft_data(ft_data), .ft_be(ft_be), .ft_rd(ft_rd), .ft_wr(ft_wr),
        .ft_oe(ft_oe), .host_din(host_din), .host_din_be(host_din_be),
        .host_din_valid(host_din_valid), .host_din_full(host_din_full),
        .host_dout(host_dout), .host_dout_be(host_dout_be),
        .host_dout_empty(host_dout_empty), .host_dout_get(host_dout_get),
        .rx_hold(rx_hold), .tx_hold(tx_hold), .rx_level(rx_level),
        .tx_level(tx_level), .err_conflict(err_conflict)
    );

    // Reference model: two word queues plus the registered flag values.
    logic [BE+BW-1:0] rx_q[$];
    logic [BE+BW-1:0] tx_q[$];
    logic             m_rxf = 1'b1;
    logic             m_txe = 1'b1;
    logic             m_err = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        rx_q.delete();
        tx_q.delete();
        m_rxf = 1'b1;
        m_txe = 1'b1;
        m_err = 1'b0;
    endtask

    // One clock: compare DUT against model, then advance the model on the edge.
    task automatic cycle();
        logic rp, rpo, tp, tpo;
        #1;
        check("ft_rxf", ft_rxf, m_rxf);
        check("ft_txe", ft_txe, m_txe);
        check("rx_level", rx_level, rx_q.size());
        check("tx_level", tx_level, tx_q.size());
        check("din_full", host_din_full, rx_q.size() == D);
        check("dout_empty", host_dout_empty, tx_q.size() == 0);
        check("err", err_conflict, m_err);
        if (tx_q.size() > 0) check("dout", {host_dout_be, host_dout}, tx_q[0]);
        if (!ft_oe && rx_q.size() > 0) check("bus", {ft_be, ft_data}, rx_q[0]);
        if (tb_drv) check("bus_release", {ft_be, ft_data}, {tb_be, tb_data});
        rp  = host_din_valid && rx_q.size() < D;
        rpo = !ft_oe && !ft_rd && !m_rxf;
        tp  = !ft_wr && !m_txe && ft_oe;
        tpo = host_dout_get && tx_q.size() > 0;
        if ((!ft_oe && !ft_wr) || (!ft_rd && ft_oe)) m_err = 1'b1;
        @(posedge clk);
        if (rpo) void'(rx_q.pop_front());
        if (rp)  rx_q.push_back({host_din_be, host_din});
        if (tpo) void'(tx_q.pop_front());
        if (tp)  tx_q.push_back({tb_be, tb_data});
        m_rxf = (rx_q.size() == 0) || rx_hold;
        m_txe = (tx_q.size() == D) || tx_hold;
        #1;
    endtask

    task automatic idle_bus();
        ft_oe = 1'b1; ft_rd = 1'b1; ft_wr = 1'b1; tb_drv = 1'b0;
        host_din_valid = 1'b0; host_dout_get = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rxf", ft_rxf, 1'b1);
        check("rst_txe", ft_txe, 1'b1);
        check("rst_lvl", {rx_level, tx_level}, '0);
        check("rst_empty", host_dout_empty, 1'b1);
        check("rst_full", host_din_full, 1'b0);
        check("rst_err", err_conflict, 1'b0);
        rst = 1'b0;
    endtask

    logic [BW-1:0] exp3 [3];

    initial begin
        // Reset and idle
        idle_bus();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle();
        check("txe_after_rst", ft_txe, 1'b0);
        check("rxf_idle", ft_rxf, 1'b1);

        // Host pushes three words, master reads them back-to-back
        exp3[0] = 16'h1111; exp3[1] = 16'h2222; exp3[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            host_din = exp3[i]; host_din_be = 2'b11; host_din_valid = 1'b1;
            cycle();
        end
        host_din_valid = 1'b0;
        ft_oe = 1'b0; ft_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rd_word", ft_data, exp3[i]);
            cycle();
        end
        idle_bus();
        #1;
        check("rd_done_rxf", ft_rxf, 1'b1);
        check("rd_done_lvl", rx_level, 0);
        cycle();

        // Master writes two words, host drains them
        ft_wr = 1'b0; tb_drv = 1'b1; tb_data = 16'hA5A5; tb_be = 2'b01;
        cycle();
        tb_data = 16'h5A5A; tb_be = 2'b11;
        cycle();
        idle_bus();
        #1;
        check("wr0", {host_dout_be, host_dout}, {2'b01, 16'hA5A5});
        check("wr_lvl2", tx_level, 2);
        host_dout_get = 1'b1;
        cycle();
        check("wr1", {host_dout_be, host_dout}, {2'b11, 16'h5A5A});
        check("wr_lvl1", tx_level, 1);
        cycle();
        host_dout_get = 1'b0;
        check("wr_lvl0", tx_level, 0);
        cycle();

        // Overfill TX: only DEPTH words stored
        ft_wr = 1'b0; tb_drv = 1'b1; tb_be = 2'b11;
        for (int i = 0; i < D + 2; i++) begin
            tb_data = BW'(16'h0100 + i);
            cycle();
        end
        idle_bus();
        #1;
        check("fill_lvl", tx_level, D);
        check("fill_txe", ft_txe, 1'b1);
        host_dout_get = 1'b1;
        for (int i = 0; i < D; i++) begin
            #1;
            check("fill_order", host_dout, 16'h0100 + i);
            cycle();
        end
        idle_bus();
        cycle();

        // rx_hold mid-burst with 10 words buffered
        for (int i = 0; i < 10; i++) begin
            host_din = BW'($urandom); host_din_be = BE'($urandom); host_din_valid = 1'b1;
            cycle();
        end
        host_din_valid = 1'b0;
        ft_oe = 1'b0; ft_rd = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rx_hold = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("hold_lvl", rx_level, 6);
        check("hold_rxf", ft_rxf, 1'b1);
        rx_hold = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        check("hold_drain", rx_level, 0);
        idle_bus();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            host_din = BW'($urandom); host_din_be = BE'($urandom);
            host_din_valid = $urandom_range(0, 1) == 1;
            host_dout_get  = $urandom_range(0, 2) == 0;
            rx_hold = $urandom_range(0, 7) == 0;
            tx_hold = $urandom_range(0, 7) == 0;
            tb_data = BW'($urandom); tb_be = BE'($urandom);
            case (mode)
                0: begin ft_oe = 1'b0; ft_rd = $urandom_range(0, 3) != 0; ft_wr = 1'b1; tb_drv = 1'b0; end
                1: begin ft_oe = 1'b1; ft_rd = 1'b1; ft_wr = $urandom_range(0, 3) == 0; tb_drv = 1'b1; end
                default: begin ft_oe = 1'b1; ft_rd = 1'b1; ft_wr = 1'b1; tb_drv = 1'b0; end
            endcase
            cycle();
        end
        idle_bus();
        rx_hold = 1'b0; tx_hold = 1'b0;
        cycle();

        // Conflict flag, then async reset mid-read
        apply_reset();
        cycle();
        ft_oe = 1'b0; ft_wr = 1'b0;
        cycle();
        idle_bus();
        for (int i = 0; i < 3; i++) cycle();
        check("err_sticky", err_conflict, 1'b1);
        for (int i = 0; i < 4; i++) begin
            host_din = 16'hBEEF; host_din_be = 2'b11; host_din_valid = 1'b1;
            cycle();
        end
        host_din_valid = 1'b0;
        ft_oe = 1'b0; ft_rd = 1'b0;
        cycle();
        #2;
        tb_drv = 1'b1; tb_data = '0; tb_be = '0;
        rst = 1'b1;
        #1;
        check("async_bus", ft_data, 16'h0000);
        check("async_be", ft_be, 2'b00);
        check("async_err", err_conflict, 1'b0);
        check("async_rxf", ft_rxf, 1'b1);
        check("async_lvl", rx_level, 0);
        idle_bus();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
